// File: rtl/tagged_rr_arbiter.sv
// Round-robin merge of N val/rdy sources onto one tagged output, with optional burst locking.
// Latency: 1 cycle through a registered output; recv_rdy is gated by the output buffer's ability to accept a word.
module tagged_rr_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int N_INPUTS  = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_INPUTS-1:0]             recv_val,
    output logic [N_INPUTS-1:0]             recv_rdy,
    input  logic [N_INPUTS*BIT_WIDTH-1:0]   recv_msg,
    output logic                            send_val,
    input  logic                            send_rdy,
    output logic [ADDR_BITS+BIT_WIDTH-1:0]  send_msg,
    input  logic                            cfg_val,
    output logic                            cfg_rdy,
    input  logic [7:0]                      cfg_msg
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_BITS-1:0]   ptr, grant, win, sel, idx;
    logic [7:0]             cnt, burst_len;
    logic                   can_acc, found, xfer;
    logic [BIT_WIDTH-1:0]   sel_dat;

    assign can_acc = !send_val || send_rdy;
    assign cfg_rdy = (state == IDLE) && !reset;

    // Search starts one past the last-served source so every source gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= N_INPUTS; k++) begin
            idx = ADDR_BITS'((int'(ptr) + k) % N_INPUTS);
            if (!found && recv_val[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        recv_rdy = '0;
        xfer     = 1'b0;
        sel      = (state == LOCKED) ? grant : win;
        if (!reset && can_acc) begin
            if (state == IDLE) begin
                recv_rdy[win] = found;
                xfer          = found;
            end else begin
                recv_rdy[grant] = 1'b1;
                xfer            = recv_val[grant];
            end
        end
    end

    assign sel_dat = recv_msg[int'(sel)*BIT_WIDTH +: BIT_WIDTH];

    // A locked source that goes idle while the buffer could accept gives up the lock.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && burst_len > 8'd1) state_nxt = LOCKED;
            LOCKED:  if (can_acc && (!recv_val[grant] || cnt == 8'd1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            send_val  <= 1'b0;
            send_msg  <= '0;
            ptr       <= ADDR_BITS'(N_INPUTS - 1);
            grant     <= '0;
            cnt       <= 8'd0;
            burst_len <= 8'd1;
        end else begin
            if (xfer) begin
                send_val <= 1'b1;
                send_msg <= {sel, sel_dat};
                ptr      <= sel;
                if (state == IDLE) begin
                    grant <= win;
                    cnt   <= burst_len - 8'd1;
                end else begin
                    cnt   <= cnt - 8'd1;
                end
            end else if (send_rdy) begin
                send_val <= 1'b0;
            end
            if (cfg_val && cfg_rdy)
                burst_len <= (cfg_msg == 8'd0) ? 8'd1 : cfg_msg;
        end
    end

endmodule

// File: tb/tb_tagged_rr_arbiter.sv
// Directed bench for tagged_rr_arbiter: expected source tags are queued per step and
// checked against each word the output hands off; payloads carry a per-source sequence number.
module tb_tagged_rr_arbiter;
    localparam int BW = 32;
    localparam int N  = 16;
    localparam int AB = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        recv_val;
    logic [N-1:0]        recv_rdy;
    logic [N*BW-1:0]     recv_msg;
    logic                send_val;
    logic                send_rdy;
    logic [AB+BW-1:0]    send_msg;
    logic                cfg_val;
    logic                cfg_rdy;
    logic [7:0]          cfg_msg;

    int                  seq     [N] = '{default: 0};
    int                  exp_seq [N] = '{default: 0};
    logic [AB-1:0]       exp_q[$];
    logic [N-1:0]        hs = '0;
    int                  vectors = 0;
    int                  miscompares = 0;

    tagged_rr_arbiter #(.BIT_WIDTH(BW), .N_INPUTS(N), .ADDR_BITS(AB)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg),
        .cfg_val  (cfg_val),
        .cfg_rdy  (cfg_rdy),
        .cfg_msg  (cfg_msg)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] payload(input int src, input int s);
        return {4'hD, 4'(src), 8'hA5, 16'(s)};
    endfunction

    function automatic logic [AB+BW-1:0] word(input int src, input int s);
        return {AB'(src), payload(src, s)};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_src
        assign recv_msg[g*BW +: BW] = payload(g, seq[g]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int t);
        exp_q.push_back(AB'(t));
    endtask

    // Sample just after the input update, i.e. well away from the rising edge.
    task automatic settle();
        logic [AB-1:0] t;
        #1;
        chk("rdy_onehot", 64'($countones(recv_rdy) <= 1), 64'd1);
        if (send_val && send_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                t = exp_q.pop_front();
                chk("send_msg", 64'(send_msg), 64'(word(int'(t), exp_seq[t])));
                exp_seq[t]++;
            end
        end
        hs = recv_val & recv_rdy;
    endtask

    task automatic advance();
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (hs[i]) seq[i]++;
        hs = '0;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drain();
        recv_val = '0;
        step();
        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic cfg(input logic [7:0] v);
        cfg_val = 1'b1;
        cfg_msg = v;
        settle();
        chk("cfg_rdy_idle", 64'(cfg_rdy), 64'd1);
        advance();
        cfg_val = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        recv_val = '1;
        send_rdy = 1'b1;
        cfg_val  = 1'b1;
        cfg_msg  = 8'd7;
        @(negedge clk);
        #1;
        chk("rst_send_val", 64'(send_val), 64'd0);
        chk("rst_send_msg", 64'(send_msg), 64'd0);
        chk("rst_recv_rdy", 64'(recv_rdy), 64'd0);
        chk("rst_cfg_rdy",  64'(cfg_rdy),  64'd0);
        @(negedge clk);
        reset    = 1'b0;
        recv_val = '0;
        cfg_val  = 1'b0;
        settle();
        chk("post_rst_send_val", 64'(send_val), 64'd0);
        chk("post_rst_cfg_rdy",  64'(cfg_rdy),  64'd1);
        advance();

        // Priority after reset: sources 0,3,5, burst length 1.
        recv_val = 16'h0029;
        for (int r = 0; r < 2; r++) begin
            push(0); push(3); push(5);
        end
        for (int s = 0; s < 6; s++) begin
            settle();
            chk("t1_send_val", 64'(send_val), 64'(s >= 1));
            advance();
        end
        drain();

        // Burst lock of 4 between sources 1 and 2.
        cfg(8'd4);
        recv_val = 16'h0006;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 4; k++) push((b == 1) ? 2 : 1);
        for (int s = 0; s < 12; s++) begin
            settle();
            chk("t2_cfg_rdy", 64'(cfg_rdy), 64'((s % 4) == 0));
            chk("t2_send_val", 64'(send_val), 64'(s >= 1));
            advance();
        end
        drain();

        // Backpressure mid-burst on source 6, then source 7 follows.
        recv_val = 16'h00C0;
        for (int k = 0; k < 4; k++) push(6);
        for (int k = 0; k < 4; k++) push(7);
        step();
        send_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            settle();
            chk("t3_recv_rdy", 64'(recv_rdy), 64'd0);
            chk("t3_send_val", 64'(send_val), 64'd1);
            chk("t3_send_msg", 64'(send_msg), 64'(word(6, exp_seq[6])));
            advance();
        end
        send_rdy = 1'b1;
        repeat (7) step();
        drain();

        // Early release: source 4 drops after 3 words, source 9 waits.
        cfg(8'd8);
        recv_val = 16'h0010;
        push(4); push(4); push(4); push(9); push(9);
        step();
        recv_val = 16'h0210;
        step();
        step();
        recv_val = 16'h0200;
        step();
        settle();
        chk("t4_bubble", 64'(send_val), 64'd0);
        advance();
        step();
        drain();

        // Zero burst length behaves as 1; cfg alongside a grant keeps the old length.
        cfg(8'd0);
        recv_val = 16'h0C00;
        push(10); push(11); push(10); push(11);
        for (int s = 0; s < 4; s++) begin
            settle();
            chk("t5_cfg_rdy", 64'(cfg_rdy), 64'd1);
            advance();
        end
        recv_val = 16'h3000;
        push(12); push(13); push(13); push(13); push(12);
        cfg(8'd3);
        for (int s = 0; s < 4; s++) begin
            settle();
            chk("t5_cfg_rdy_lock", 64'(cfg_rdy), 64'((s == 0) || (s == 3)));
            advance();
        end
        drain();

        // Reset in the middle of a source-14 burst.
        recv_val = 16'h4001;
        push(14);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("t6_send_val", 64'(send_val), 64'd0);
        chk("t6_recv_rdy", 64'(recv_rdy), 64'd0);
        chk("t6_cfg_rdy",  64'(cfg_rdy),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_seq[14]++;  // the buffered second word is discarded by reset
        push(0); push(14);
        step();
        step();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
